// File: rtl/regfile_dump_reader.sv
// Reads registers FirstReg..LastReg (mod 32) through RA/BusA and streams them out over valid/ready.
// Define REGDUMP_CHECKSUM_EN to append an XOR-checksum beat after the last register.
module regfile_dump_reader #(
    parameter int READ_WAIT = 1
) (
    input  logic        Clk,
    input  logic        ResetL,
    input  logic        Start,
    input  logic [4:0]  FirstReg,
    input  logic [4:0]  LastReg,
    output logic [4:0]  RA,
    input  logic [63:0] BusA,
    output logic [63:0] DataOut,
    output logic [4:0]  DataIndex,
    output logic        DataIsSum,
    output logic        DataValid,
    input  logic        DataReady,
    output logic        Busy,
    output logic        Done
);
    localparam int CW = (READ_WAIT < 2) ? 1 : $clog2(READ_WAIT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_HOLD,
`ifdef REGDUMP_CHECKSUM_EN
        S_SUM,
`endif
        S_FIN
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [4:0]      r_ra;
    logic [4:0]      r_last;
    logic [CW-1:0]   r_wait_cnt;
    logic [63:0]     r_data;
    logic [4:0]      r_index;
`ifdef REGDUMP_CHECKSUM_EN
    logic [63:0]     r_sum;
`endif

    logic w_wait_done;
    logic w_last;

    assign w_wait_done = (r_wait_cnt == CW'(1));
    assign w_last      = (r_ra == r_last);

    always_ff @(posedge Clk or negedge ResetL) begin
        if (!ResetL) r_state <= S_IDLE;
        else         r_state <= w_state_nxt;
    end

    // NOTE: next state defaults to the current state first, so no path through this block can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (Start)       w_state_nxt = S_WAIT;
            S_WAIT: if (w_wait_done) w_state_nxt = S_HOLD;
            S_HOLD: if (DataReady) begin
`ifdef REGDUMP_CHECKSUM_EN
                w_state_nxt = w_last ? S_SUM : S_WAIT;
`else
                w_state_nxt = w_last ? S_FIN : S_WAIT;
`endif
            end
`ifdef REGDUMP_CHECKSUM_EN
            S_SUM:  if (DataReady)   w_state_nxt = S_FIN;
`endif
            S_FIN:                   w_state_nxt = S_IDLE;
            default:                 w_state_nxt = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge Clk or negedge ResetL) begin
        if (!ResetL) begin
            r_ra       <= '0;
            r_last     <= '0;
            r_wait_cnt <= '0;
            r_data     <= '0;
            r_index    <= '0;
`ifdef REGDUMP_CHECKSUM_EN
            r_sum      <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: if (Start) begin
                    r_ra       <= FirstReg;
                    r_last     <= LastReg;
                    r_wait_cnt <= CW'(READ_WAIT);
`ifdef REGDUMP_CHECKSUM_EN
                    r_sum      <= '0;
`endif
                end
                S_WAIT: begin
                    if (w_wait_done) begin
                        r_data  <= BusA;
                        r_index <= r_ra;
                    end else begin
                        r_wait_cnt <= r_wait_cnt - CW'(1);
                    end
                end
                S_HOLD: if (DataReady) begin
`ifdef REGDUMP_CHECKSUM_EN
                    r_sum <= r_sum ^ r_data;
`endif
                    if (!w_last) begin
                        r_ra       <= r_ra + 5'd1;
                        r_wait_cnt <= CW'(READ_WAIT);
                    end
`ifdef REGDUMP_CHECKSUM_EN
                    else begin
                        // Checksum beat reuses the data/index registers.
                        r_data  <= r_sum ^ r_data;
                        r_index <= '0;
                    end
`endif
                end
                default: ;
            endcase
        end
    end

    assign RA        = r_ra;
    assign DataOut   = r_data;
    assign DataIndex = r_index;
    assign Done      = (r_state == S_FIN);
    assign Busy      = (r_state != S_IDLE) && (r_state != S_FIN);
`ifdef REGDUMP_CHECKSUM_EN
    assign DataIsSum = (r_state == S_SUM);
    assign DataValid = (r_state == S_HOLD) || (r_state == S_SUM);
`else
    assign DataIsSum = 1'b0;
    assign DataValid = (r_state == S_HOLD);
`endif

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Randomized bench for regfile_dump_reader: register-file model on RA/BusA, expected beat list from window arithmetic.
// Follows REGDUMP_CHECKSUM_EN to expect the checksum beat.
module tb_regfile_dump_reader;
    localparam int RW = 1;
`ifdef REGDUMP_CHECKSUM_EN
    localparam int CSUM = 1;
`else
    localparam int CSUM = 0;
`endif

    logic        Clk = 1'b0;
    logic        ResetL, Start, DataReady;
    logic [4:0]  FirstReg, LastReg, RA, DataIndex;
    logic [63:0] BusA, DataOut;
    logic        DataIsSum, DataValid, Busy, Done;

    logic [63:0] regs [32];
    assign BusA = regs[RA];

    always #5 Clk = ~Clk;

    regfile_dump_reader #(.READ_WAIT(RW)) dut (
        .Clk(Clk), .ResetL(ResetL), .Start(Start), .FirstReg(FirstReg), .LastReg(LastReg),
        .RA(RA), .BusA(BusA), .DataOut(DataOut), .DataIndex(DataIndex), .DataIsSum(DataIsSum),
        .DataValid(DataValid), .DataReady(DataReady), .Busy(Busy), .Done(Done)
    );

    int n_vec = 0;
    int n_miss = 0;

    // Observed beats and run statistics from the last dump.
    logic [4:0]  q_idx [$];
    logic [63:0] q_val [$];
    bit          q_sum [$];
    int          done_at, hold_viol;
    logic        busy_at_done, done_after;

    // Expected beats from the reference model.
    logic [4:0]  e_idx [$];
    logic [63:0] e_val [$];
    bit          e_sum [$];
    int          e_n, e_cycles;

    task automatic rand_regs();
        for (int i = 0; i < 31; i++) regs[i] = {$urandom, $urandom};
        regs[31] = 64'd0;
    endtask

    task automatic build_expect(input logic [4:0] first, input logic [4:0] last, input int stall);
        logic [63:0] x = 64'd0;
        e_idx.delete(); e_val.delete(); e_sum.delete();
        e_n = ((int'(last) - int'(first) + 32) % 32) + 1;
        for (int i = 0; i < e_n; i++) begin
            int r = (int'(first) + i) % 32;
            e_idx.push_back(5'(r));
            e_val.push_back(regs[r]);
            e_sum.push_back(1'b0);
            x = x ^ regs[r];
        end
        if (CSUM != 0) begin
            e_idx.push_back(5'd0);
            e_val.push_back(x);
            e_sum.push_back(1'b1);
        end
        e_cycles = e_n * (RW + 1) + CSUM + stall;
    endtask

    task automatic run_dump(input logic [4:0] first, input logic [4:0] last, input int stall_beat,
                            input int stall_len, input bit repulse, input bit rnd_ready);
        int          stall_left = stall_len;
        bit          was_stalled = 1'b0;
        logic [63:0] h_val;
        logic [4:0]  h_idx, h_ra;
        q_idx.delete(); q_val.delete(); q_sum.delete();
        done_at = -1; hold_viol = 0; busy_at_done = 1'b1; done_after = 1'b1;
        @(negedge Clk);
        FirstReg = first; LastReg = last; Start = 1'b1; DataReady = 1'b1;
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(negedge Clk);
            Start = 1'b0;
            if (repulse && cyc == 0) begin
                Start = 1'b1; FirstReg = first + 5'd3; LastReg = first + 5'd9;
            end
            if (was_stalled && (DataValid !== 1'b1 || DataOut !== h_val || DataIndex !== h_idx || RA !== h_ra))
                hold_viol++;
            was_stalled = 1'b0;
            if (Done === 1'b1) begin
                done_at = cyc; busy_at_done = Busy;
                break;
            end
            if (rnd_ready) DataReady = 1'($urandom_range(0, 1));
            else if (DataValid === 1'b1 && q_idx.size() == stall_beat && stall_left > 0) begin
                DataReady = 1'b0; stall_left--;
            end else DataReady = 1'b1;
            if (DataValid === 1'b1) begin
                if (DataReady) begin
                    q_idx.push_back(DataIndex); q_val.push_back(DataOut); q_sum.push_back(DataIsSum);
                end else begin
                    was_stalled = 1'b1; h_val = DataOut; h_idx = DataIndex; h_ra = RA;
                end
            end
        end
        Start = 1'b0; DataReady = 1'b1;
        @(negedge Clk);
        done_after = Done;
    endtask

    task automatic test_reset();
        ResetL = 1'b0; Start = 1'b0; DataReady = 1'b0; FirstReg = '0; LastReg = '0;
        repeat (2) @(negedge Clk);
        n_vec++;
        if ({RA, DataOut, DataIndex, DataIsSum, DataValid, Busy, Done} !== '0) begin
            n_miss++;
            $display("FAIL reset_outputs: got RA=%0d out=%h idx=%0d sum=%b v=%b busy=%b done=%b want all 0",
                     RA, DataOut, DataIndex, DataIsSum, DataValid, Busy, Done);
        end
        ResetL = 1'b1; DataReady = 1'b1;
        repeat (2) @(negedge Clk);
        n_vec++;
        if (Busy !== 1'b0 || Done !== 1'b0 || DataValid !== 1'b0) begin
            n_miss++;
            $display("FAIL reset_idle: got busy=%b done=%b v=%b want 0 0 0", Busy, Done, DataValid);
        end
    endtask

    task automatic test_basic();
        for (int i = 0; i < 31; i++) regs[i] = 64'(i) * 64'h1111;
        regs[31] = 64'd0;
        run_dump(5'd9, 5'd13, -1, 0, 1'b0, 1'b0);
        build_expect(5'd9, 5'd13, 0);
        n_vec++;
        if (q_idx.size() !== e_idx.size()) begin
            n_miss++; $display("FAIL basic_count: got %0d want %0d", q_idx.size(), e_idx.size());
        end
        for (int i = 0; i < e_idx.size() && i < q_idx.size(); i++) begin
            n_vec++;
            if (q_idx[i] !== e_idx[i] || q_val[i] !== e_val[i] || q_sum[i] !== e_sum[i]) begin
                n_miss++;
                $display("FAIL basic_beat%0d: got idx=%0d val=%h sum=%b want idx=%0d val=%h sum=%b",
                         i, q_idx[i], q_val[i], q_sum[i], e_idx[i], e_val[i], e_sum[i]);
            end
        end
        n_vec++;
        if (done_at !== e_cycles || busy_at_done !== 1'b0 || done_after !== 1'b0) begin
            n_miss++;
            $display("FAIL basic_done: got cycles=%0d busy=%b done_next=%b want %0d 0 0",
                     done_at, busy_at_done, done_after, e_cycles);
        end
    endtask

    task automatic test_wrap();
        rand_regs();
        run_dump(5'd30, 5'd1, -1, 0, 1'b0, 1'b0);
        build_expect(5'd30, 5'd1, 0);
        n_vec++;
        if (q_idx.size() !== e_idx.size()) begin
            n_miss++; $display("FAIL wrap_count: got %0d want %0d", q_idx.size(), e_idx.size());
        end
        for (int i = 0; i < e_idx.size() && i < q_idx.size(); i++) begin
            n_vec++;
            if (q_idx[i] !== e_idx[i] || q_val[i] !== e_val[i] || q_sum[i] !== e_sum[i]) begin
                n_miss++;
                $display("FAIL wrap_beat%0d: got idx=%0d val=%h want idx=%0d val=%h",
                         i, q_idx[i], q_val[i], e_idx[i], e_val[i]);
            end
        end
        n_vec++;
        if (done_at !== e_cycles) begin
            n_miss++; $display("FAIL wrap_done: got %0d want %0d", done_at, e_cycles);
        end
    endtask

    task automatic test_backpressure();
        rand_regs();
        run_dump(5'd4, 5'd8, 1, 7, 1'b0, 1'b0);
        build_expect(5'd4, 5'd8, 7);
        n_vec++;
        if (hold_viol !== 0) begin
            n_miss++; $display("FAIL bp_hold: got %0d unstable stall cycles want 0", hold_viol);
        end
        n_vec++;
        if (q_idx.size() !== e_idx.size()) begin
            n_miss++; $display("FAIL bp_count: got %0d want %0d", q_idx.size(), e_idx.size());
        end
        for (int i = 0; i < e_idx.size() && i < q_idx.size(); i++) begin
            n_vec++;
            if (q_idx[i] !== e_idx[i] || q_val[i] !== e_val[i] || q_sum[i] !== e_sum[i]) begin
                n_miss++;
                $display("FAIL bp_beat%0d: got idx=%0d val=%h want idx=%0d val=%h",
                         i, q_idx[i], q_val[i], e_idx[i], e_val[i]);
            end
        end
        n_vec++;
        if (done_at !== e_cycles) begin
            n_miss++; $display("FAIL bp_done: got %0d want %0d", done_at, e_cycles);
        end
    endtask

    task automatic test_restart_ignored();
        int busy_seen = 0;
        rand_regs();
        run_dump(5'd5, 5'd5, -1, 0, 1'b1, 1'b0);
        build_expect(5'd5, 5'd5, 0);
        n_vec++;
        if (q_idx.size() !== e_idx.size() || (q_idx.size() > 0 && (q_idx[0] !== 5'd5 || q_val[0] !== regs[5]))) begin
            n_miss++;
            $display("FAIL restart_beats: got count=%0d want %0d single word idx 5", q_idx.size(), e_idx.size());
        end
        n_vec++;
        if (done_at !== e_cycles) begin
            n_miss++; $display("FAIL restart_done: got %0d want %0d", done_at, e_cycles);
        end
        repeat (4) begin
            @(negedge Clk);
            if (Busy !== 1'b0 || Done !== 1'b0) busy_seen++;
        end
        n_vec++;
        if (busy_seen !== 0) begin
            n_miss++; $display("FAIL restart_queued: got %0d active cycles after Done want 0", busy_seen);
        end
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        int stray = 0;
        rand_regs();
        @(negedge Clk);
        FirstReg = 5'd0; LastReg = 5'd10; Start = 1'b1; DataReady = 1'b1;
        for (int cyc = 0; cyc < 100 && seen < 3; cyc++) begin
            @(negedge Clk);
            Start = 1'b0;
            if (DataValid === 1'b1) begin
                seen++;
                DataReady = (seen < 3);
            end
        end
        n_vec++;
        if (seen !== 3) begin
            n_miss++; $display("FAIL rstmid_reach: got %0d beats want 3", seen);
        end
        #2 ResetL = 1'b0;
        #1;
        n_vec++;
        if ({RA, DataOut, DataIndex, DataIsSum, DataValid, Busy, Done} !== '0) begin
            n_miss++;
            $display("FAIL rstmid_async: got RA=%0d out=%h idx=%0d v=%b busy=%b done=%b want all 0",
                     RA, DataOut, DataIndex, DataValid, Busy, Done);
        end
        repeat (2) @(negedge Clk);
        ResetL = 1'b1; DataReady = 1'b1;
        repeat (25) begin
            @(negedge Clk);
            if (Done !== 1'b0 || Busy !== 1'b0) stray++;
        end
        n_vec++;
        if (stray !== 0) begin
            n_miss++; $display("FAIL rstmid_nodone: got %0d active cycles want 0", stray);
        end
        run_dump(5'd2, 5'd6, -1, 0, 1'b0, 1'b0);
        build_expect(5'd2, 5'd6, 0);
        n_vec++;
        if (q_idx.size() !== e_idx.size() || done_at !== e_cycles) begin
            n_miss++;
            $display("FAIL rstmid_fresh: got count=%0d cycles=%0d want %0d %0d", q_idx.size(), done_at, e_idx.size(), e_cycles);
        end
        for (int i = 0; i < e_idx.size() && i < q_idx.size(); i++) begin
            n_vec++;
            if (q_idx[i] !== e_idx[i] || q_val[i] !== e_val[i] || q_sum[i] !== e_sum[i]) begin
                n_miss++;
                $display("FAIL rstmid_beat%0d: got idx=%0d val=%h want idx=%0d val=%h",
                         i, q_idx[i], q_val[i], e_idx[i], e_val[i]);
            end
        end
    endtask

    task automatic test_checksum();
        rand_regs();
        regs[3] = 64'hF0; regs[4] = 64'h0F; regs[5] = 64'hFF;
        run_dump(5'd3, 5'd5, -1, 0, 1'b0, 1'b0);
        build_expect(5'd3, 5'd5, 0);
        n_vec++;
        if (q_idx.size() !== e_idx.size() || done_at !== e_cycles) begin
            n_miss++;
            $display("FAIL csum_count: got count=%0d cycles=%0d want %0d %0d", q_idx.size(), done_at, e_idx.size(), e_cycles);
        end
        for (int i = 0; i < e_idx.size() && i < q_idx.size(); i++) begin
            n_vec++;
            if (q_idx[i] !== e_idx[i] || q_val[i] !== e_val[i] || q_sum[i] !== e_sum[i]) begin
                n_miss++;
                $display("FAIL csum_beat%0d: got idx=%0d val=%h sum=%b want idx=%0d val=%h sum=%b",
                         i, q_idx[i], q_val[i], q_sum[i], e_idx[i], e_val[i], e_sum[i]);
            end
        end
    endtask

    task automatic test_random();
        for (int t = 0; t < 8; t++) begin
            logic [4:0] f, l;
            rand_regs();
            f = 5'($urandom); l = 5'($urandom);
            run_dump(f, l, -1, 0, 1'b0, 1'b1);
            build_expect(f, l, 0);
            n_vec++;
            if (q_idx.size() !== e_idx.size() || hold_viol !== 0 || done_at < 0 || busy_at_done !== 1'b0 || done_after !== 1'b0) begin
                n_miss++;
                $display("FAIL rand%0d_run: got count=%0d holdviol=%0d done_at=%0d busy=%b done_next=%b want count=%0d 0 >=0 0 0",
                         t, q_idx.size(), hold_viol, done_at, busy_at_done, done_after, e_idx.size());
            end
            for (int i = 0; i < e_idx.size() && i < q_idx.size(); i++) begin
                n_vec++;
                if (q_idx[i] !== e_idx[i] || q_val[i] !== e_val[i] || q_sum[i] !== e_sum[i]) begin
                    n_miss++;
                    $display("FAIL rand%0d_beat%0d: got idx=%0d val=%h sum=%b want idx=%0d val=%h sum=%b",
                             t, i, q_idx[i], q_val[i], q_sum[i], e_idx[i], e_val[i], e_sum[i]);
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = 64'd0;
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_restart_ignored();
        test_reset_mid();
        test_checksum();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
